// File: rtl/cordic_vector_iter.sv
// Iterative vectoring-mode CORDIC.
// Accepts one (x, y) pair and runs ITERATIONS micro-rotations, one per clock.
// It then presents the gain-scaled magnitude and the angle until downstream
// takes the result. The operands are first folded into the right half-plane
// so the micro-rotations converge over the full -pi..+pi range.
module cordic_vector_iter #(
  parameter int ITERATIONS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [16:0]  x_i,
  input  logic signed [16:0]  y_i,
  output logic                out_valid,
  input  logic                out_ready,
  output logic        [18:0]  mag_o,
  output logic signed [17:0]  theta_o
);

  localparam int DATA_W  = 17;
  localparam int ACC_W   = 20;
  localparam int MAG_W   = 19;
  localparam int THETA_W = 18;
  localparam int CNT_W   = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;

  localparam logic [CNT_W-1:0]        LAST_CNT = CNT_W'(ITERATIONS - 1);
  localparam logic signed [ACC_W-1:0] HALF_PI  = 20'sd51472;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic        [CNT_W-1:0]  cnt;
  logic signed [ACC_W-1:0]  x_p0, y_p0, z_p0;
  logic                     zero_p0;

  logic signed [ACC_W-1:0]  x_pre, y_pre, z_pre;
  logic signed [ACC_W-1:0]  x_sh, y_sh, atan_i;
  logic                     accept;

  // Arctangent table, round(atan(2^-i) * 32768); beyond the table the
  // rotation angle is below one LSB and contributes nothing.
  function automatic logic signed [ACC_W-1:0] atan_lut(input int idx);
    logic signed [ACC_W-1:0] r;
    case (idx)
      0:       r = 20'sd25736;
      1:       r = 20'sd15193;
      2:       r = 20'sd8027;
      3:       r = 20'sd4075;
      4:       r = 20'sd2045;
      5:       r = 20'sd1024;
      6:       r = 20'sd512;
      7:       r = 20'sd256;
      8:       r = 20'sd128;
      9:       r = 20'sd64;
      10:      r = 20'sd32;
      11:      r = 20'sd16;
      12:      r = 20'sd8;
      13:      r = 20'sd4;
      14:      r = 20'sd2;
      15:      r = 20'sd1;
      default: r = 20'sd0;
    endcase
    return r;
  endfunction

  // Sign-extend an operand to the internal datapath width.
  function automatic logic signed [ACC_W-1:0] sext(input logic signed [DATA_W-1:0] v);
    return {{(ACC_W - DATA_W){v[DATA_W-1]}}, v};
  endfunction

  // Magnitude is never negative after pre-rotation, so dropping the top bit is exact.
  function automatic logic [MAG_W-1:0] trunc_mag(input logic signed [ACC_W-1:0] v);
    return v[MAG_W-1:0];
  endfunction

  // Angle stays within +/-pi*32768, which fits the narrower signed field.
  function automatic logic signed [THETA_W-1:0] trunc_theta(input logic signed [ACC_W-1:0] v);
    return v[THETA_W-1:0];
  endfunction

  assign accept    = (state == S_IDLE) && in_valid;
  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

  assign x_sh   = x_p0 >>> cnt;
  assign y_sh   = y_p0 >>> cnt;
  assign atan_i = atan_lut(int'(cnt));

  // Fold the operand into the right half-plane with a +/-90 degree pre-rotation.
  always_comb begin
    x_pre = sext(x_i);
    y_pre = sext(y_i);
    z_pre = '0;
    if (x_i[DATA_W-1]) begin
      if (!y_i[DATA_W-1]) begin
        x_pre = sext(y_i);
        y_pre = -sext(x_i);
        z_pre = HALF_PI;
      end else begin
        x_pre = -sext(y_i);
        y_pre = sext(x_i);
        z_pre = -HALF_PI;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: accept, iterate ITERATIONS times, hold until taken.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (in_valid)         state_nxt = S_ITER;
      S_ITER:  if (cnt == LAST_CNT)  state_nxt = S_DONE;
      S_DONE:  if (out_ready)        state_nxt = S_IDLE;
      default:                       state_nxt = S_IDLE;
    endcase
  end

  // Datapath: load the pre-rotated operand on acceptance, then one
  // micro-rotation per cycle; values hold in DONE so outputs stay stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      x_p0    <= '0;
      y_p0    <= '0;
      z_p0    <= '0;
      zero_p0 <= 1'b0;
    end else if (accept) begin
      cnt     <= '0;
      x_p0    <= x_pre;
      y_p0    <= y_pre;
      z_p0    <= z_pre;
      zero_p0 <= (x_i == '0) && (y_i == '0);
    end else if (state == S_ITER) begin
      cnt <= cnt + CNT_W'(1);
      if (!y_p0[ACC_W-1]) begin
        x_p0 <= x_p0 + y_sh;
        y_p0 <= y_p0 - x_sh;
        z_p0 <= z_p0 + atan_i;
      end else begin
        x_p0 <= x_p0 - y_sh;
        y_p0 <= y_p0 + x_sh;
        z_p0 <= z_p0 - atan_i;
      end
    end
  end

  assign mag_o   = zero_p0 ? '0 : trunc_mag(x_p0);
  assign theta_o = zero_p0 ? '0 : trunc_theta(z_p0);

endmodule

// File: tb/tb_cordic_vector_iter.sv
// Directed bench for cordic_vector_iter with a result scoreboard.
module tb_cordic_vector_iter;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [16:0] x_i;
  logic signed [16:0] y_i;
  logic               out_valid;
  logic               out_ready;
  logic        [18:0] mag_o;
  logic signed [17:0] theta_o;

  localparam real GAIN = 1.6467602581;
  localparam real PI   = 3.14159265358979;

  int n_cmp  = 0;
  int n_fail = 0;

  // Scoreboard: reference angle/magnitude and tolerances per accepted operand.
  real exp_theta_q[$];
  real exp_mag_q[$];
  int  tol_theta_q[$];
  int  tol_mag_q[$];
  bit  zero_q[$];

  cordic_vector_iter #(.ITERATIONS(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_i       (x_i),
    .y_i       (y_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .mag_o     (mag_o),
    .theta_o   (theta_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input longint obs, input longint exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic check_tol(input string tag, input longint obs, input real ref_v, input int tol);
    real d;
    logic ok;
    d = real'(obs) - ref_v;
    if (d < 0.0) d = -d;
    ok = (d <= real'(tol));
    n_cmp++;
    assert (ok === 1'b1) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %f +/-%0d", tag, obs, ref_v, tol);
    end
  endtask

  task automatic push_expect(input int xv, input int yv, input int ttol, input int mtol);
    if (xv == 0 && yv == 0) begin
      exp_theta_q.push_back(0.0);
      exp_mag_q.push_back(0.0);
      zero_q.push_back(1'b1);
    end else begin
      exp_theta_q.push_back($atan2(real'(yv), real'(xv)) * 32768.0);
      exp_mag_q.push_back(GAIN * $sqrt(real'(xv) * real'(xv) + real'(yv) * real'(yv)));
      zero_q.push_back(1'b0);
    end
    tol_theta_q.push_back(ttol);
    tol_mag_q.push_back(mtol);
  endtask

  // mtol < 0 means the magnitude is not checked for this operand.
  task automatic run_op(input string tag, input int xv, input int yv,
                        input int ttol, input int mtol, input int hold);
    int                 lat;
    real                et, em;
    int                 tt, tm;
    bit                 zz;
    logic        [18:0] m_hold;
    logic signed [17:0] t_hold;

    lat = 0;
    while (in_ready !== 1'b1 && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    check_eq({tag, " in_ready idle"}, longint'(in_ready), 1);

    x_i       = 17'(xv);
    y_i       = 17'(yv);
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk);
    push_expect(xv, yv, ttol, mtol);
    #1;
    check_eq({tag, " in_ready busy"}, longint'(in_ready), 0);

    // Keep in_valid high with junk operands while busy; none of it may matter.
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      x_i = 17'($urandom);
      y_i = 17'($urandom);
      @(posedge clk); #1; lat++;
    end
    in_valid = 1'b0;
    check_eq({tag, " latency"}, lat, 16);

    check_eq({tag, " sb nonempty"}, exp_theta_q.size(), 1);
    if (exp_theta_q.size() > 0) begin
      et = exp_theta_q.pop_front();
      em = exp_mag_q.pop_front();
      tt = tol_theta_q.pop_front();
      tm = tol_mag_q.pop_front();
      zz = zero_q.pop_front();
      if (zz) begin
        check_eq({tag, " mag zero"},   longint'(mag_o), 0);
        check_eq({tag, " theta zero"}, longint'(theta_o), 0);
      end else begin
        check_tol({tag, " theta"}, longint'(theta_o), et, tt);
        if (tm >= 0) check_tol({tag, " mag"}, longint'(mag_o), em, tm);
      end
    end

    m_hold = mag_o;
    t_hold = theta_o;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check_eq({tag, " bp out_valid"}, longint'(out_valid), 1);
      check_eq({tag, " bp in_ready"},  longint'(in_ready), 0);
      check_eq({tag, " bp mag"},       longint'(mag_o), longint'(m_hold));
      check_eq({tag, " bp theta"},     longint'(theta_o), longint'(t_hold));
    end

    out_ready = 1'b1;
    @(posedge clk); #1;
    check_eq({tag, " taken out_valid"}, longint'(out_valid), 0);
    check_eq({tag, " taken in_ready"},  longint'(in_ready), 1);
    out_ready = 1'b0;
  endtask

  initial begin
    int  seen;
    real a;
    int  xs, ys;

    rst       = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    x_i       = 17'sd1000;
    y_i       = 17'sd1000;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst      = 1'b0;
    check_eq("reset in_ready",  longint'(in_ready), 1);
    check_eq("reset out_valid", longint'(out_valid), 0);
    check_eq("reset mag",       longint'(mag_o), 0);
    check_eq("reset theta",     longint'(theta_o), 0);

    run_op("p0deg",    32768,      0, 2,  8, 0);
    run_op("p45deg",   23170,  23170, 4,  8, 5);
    run_op("p90deg",       0,  32768, 4,  8, 0);
    run_op("p180deg", -32768,      0, 4, -1, 0);
    run_op("m135deg", -23170, -23170, 4, -1, 0);
    run_op("zero",         0,      0, 0,  0, 0);

    // Abort an operation with reset at iteration 7.
    x_i      = 17'sd32767;
    y_i      = 17'sd0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq("abort accepted", longint'(in_ready), 0);
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("abort in_ready",  longint'(in_ready), 1);
    check_eq("abort out_valid", longint'(out_valid), 0);
    check_eq("abort mag",       longint'(mag_o), 0);
    check_eq("abort theta",     longint'(theta_o), 0);
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen = 1;
    end
    check_eq("abort no result", seen, 0);
    run_op("post_abort", 32768, 0, 2, 8, 0);

    // Unit-circle sweep 0..90 degrees.
    for (int d = 0; d <= 90; d++) begin
      a  = real'(d) * PI / 180.0;
      xs = int'(32768.0 * $cos(a));
      ys = int'(32768.0 * $sin(a));
      run_op($sformatf("sweep%0d", d), xs, ys, 4, -1, 0);
    end

    check_eq("scoreboard drained", exp_theta_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cordic_vector_iter.md
CORDIC_VECTOR_ITER -- requirements
Module: cordic_vector_iter

Interface
REQ-001 The block SHALL have the following parameter: ITERATIONS, 16, number of CORDIC micro-rotations performed per operation.
REQ-002 The block SHALL have the following ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  reset, synchronous and active-high.
- in_valid  input  1  x_i/y_i hold a valid operand pair.
- in_ready  output  1  block can accept an operand pair.
- x_i  input  17  signed operand x, U(1,15) scaling (32768 = 1.0).
- y_i  input  17  signed operand y, same scaling.
- out_valid  output  1  mag_o/theta_o hold a result.
- out_ready  input  1  downstream accepts the result.
- mag_o  output  19  unsigned magnitude, carrying the uncompensated CORDIC gain (about 1.64676 x true magnitude).
- theta_o  output  18  signed angle, radians x 32768, range -102944..+102944.

Function
REQ-003 The block SHALL implement a three-state machine: IDLE, ITER and DONE.
REQ-004 In IDLE, in_ready SHALL be 1 and out_valid SHALL be 0; in_ready SHALL be 0 in every other state.
REQ-005 An operand pair SHALL be accepted on a rising edge where in_valid=1 and in_ready=1; that edge SHALL move the state to ITER with the iteration counter at 0.
REQ-006 On acceptance, the block SHALL pre-rotate the operands into the right half-plane:
- x>=0: (x,y,z) = (x, y, 0).
- x<0 and y>=0: (x,y,z) = (y, -x, +51472).
- x<0 and y<0: (x,y,z) = (-y, x, -51472).
REQ-007 Internal x, y and z datapaths SHALL be 20-bit signed and sign-extended from the inputs, so that no overflow occurs for any 17-bit operand.
REQ-008 Each ITER edge with counter i SHALL perform one micro-rotation using arithmetic right shifts:
- y>=0: x += y>>>i; y -= x>>>i; z += atan_i.
- y<0: the opposite signs on all three updates.
- All updates use the values from before the edge.
REQ-009 atan_i SHALL equal round(atan(2^-i) x 32768), held in a constant table: 25736, 15193, 8027, 4075, 2045, 1024, 512, 256, 128, 64, 32, 16, 8, 4, 2, 1.
REQ-010 The edge with counter = ITERATIONS-1 SHALL move the state to DONE; out_valid SHALL rise exactly ITERATIONS (16) edges after the accepting edge.
REQ-011 In DONE, out_valid SHALL be 1; mag_o SHALL equal the final x truncated to 19 bits, and theta_o SHALL equal the final z truncated to 18 bits.
REQ-012 mag_o and theta_o SHALL be held stable while out_valid=1 and out_ready=0, for any number of cycles.
REQ-013 A rising edge with out_valid=1 and out_ready=1 SHALL return the state to IDLE; in_ready SHALL be 1 in the following cycle.
REQ-014 No new operand SHALL be accepted in the same cycle a result is taken; minimum throughput is one result per ITERATIONS+2 cycles.
REQ-015 If x_i=0 and y_i=0 at acceptance, a latched zero flag SHALL force mag_o=0 and theta_o=0 in DONE, while iteration timing is unchanged.
REQ-016 in_valid SHALL be ignored outside IDLE, and x_i/y_i changes after acceptance SHALL NOT affect the result.
REQ-017 out_ready SHALL be ignored outside DONE.

Reset
REQ-018 While rst=1 at a rising edge, the state SHALL become IDLE, and the counter, x, y, z and the zero flag SHALL all be cleared.
REQ-019 After reset, the outputs SHALL be: in_ready=1, out_valid=0, mag_o=0, theta_o=0.
REQ-020 A reset asserted in ITER or DONE SHALL abort the operation, with no result emitted; the first cycle after rst deasserts SHALL present in_ready=1.
REQ-021 rst SHALL take priority over in_valid and out_ready on the same edge.

Verification
REQ-022 The bench SHALL cover the following directed scenarios:
- (x,y) = (32768, 0), out_ready=1 -> out_valid exactly 16 edges after acceptance; theta_o = 0 +/-2; mag_o = 53961 +/-8.
- (23170, 23170) -> theta_o = 25736 +/-4; mag_o = 53961 +/-8.
- (0, 32768) -> theta_o = 51472 +/-4; mag_o = 53961 +/-8.
- (-32768, 0) -> theta_o = 102944 +/-4.
- (-23170, -23170) -> theta_o = -77208 +/-4.
- (0, 0) -> mag_o = 0, theta_o = 0, latency still 16.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0; then the result is taken and in_ready=1 on the next cycle.
- rst pulsed at ITER counter 7 -> no out_valid pulse; the next operand (32768, 0) completes normally.
- Sweep 0..90 degrees in 1-degree steps on the unit circle -> |theta_o - angle x 32768| <= 4 for every step.
